// File: rtl/ps2_pkg.sv
// Shared types, constants and the set-2 scancode to ASCII lookup for the PS/2 keyboard front end.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rxState_e;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam int         ENTRY_W   = 9;

    // Returns {hit, ascii}; hit is 0 for codes with no printable mapping.
    function automatic logic [8:0] scanToAscii(input logic [7:0] code);
        logic [8:0] result;
        result = 9'h000;
        case (code)
            8'h1C: result = {1'b1, 8'h61};
            8'h32: result = {1'b1, 8'h62};
            8'h21: result = {1'b1, 8'h63};
            8'h23: result = {1'b1, 8'h64};
            8'h24: result = {1'b1, 8'h65};
            8'h2B: result = {1'b1, 8'h66};
            8'h34: result = {1'b1, 8'h67};
            8'h33: result = {1'b1, 8'h68};
            8'h43: result = {1'b1, 8'h69};
            8'h3B: result = {1'b1, 8'h6A};
            8'h42: result = {1'b1, 8'h6B};
            8'h4B: result = {1'b1, 8'h6C};
            8'h3A: result = {1'b1, 8'h6D};
            8'h31: result = {1'b1, 8'h6E};
            8'h44: result = {1'b1, 8'h6F};
            8'h4D: result = {1'b1, 8'h70};
            8'h15: result = {1'b1, 8'h71};
            8'h2D: result = {1'b1, 8'h72};
            8'h1B: result = {1'b1, 8'h73};
            8'h2C: result = {1'b1, 8'h74};
            8'h3C: result = {1'b1, 8'h75};
            8'h2A: result = {1'b1, 8'h76};
            8'h1D: result = {1'b1, 8'h77};
            8'h22: result = {1'b1, 8'h78};
            8'h35: result = {1'b1, 8'h79};
            8'h1A: result = {1'b1, 8'h7A};
            8'h45: result = {1'b1, 8'h30};
            8'h16: result = {1'b1, 8'h31};
            8'h1E: result = {1'b1, 8'h32};
            8'h26: result = {1'b1, 8'h33};
            8'h25: result = {1'b1, 8'h34};
            8'h2E: result = {1'b1, 8'h35};
            8'h36: result = {1'b1, 8'h36};
            8'h3D: result = {1'b1, 8'h37};
            8'h3E: result = {1'b1, 8'h38};
            8'h46: result = {1'b1, 8'h39};
            8'h29: result = {1'b1, 8'h20};
            8'h5A: result = {1'b1, 8'h0D};
            8'h66: result = {1'b1, 8'h08};
            default: result = 9'h000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronisers, falling-edge detect, framing FSM,
// odd-parity and stop-bit check, and an inactivity timeout that abandons partial frames.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2Clk_i,
    input  logic       ps2Data_i,
    output logic [7:0] rxByte_o,
    output logic       byteValid_o
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]      clkSync_q;
    logic [1:0]      dataSync_q;
    logic            clkPrev_q;
    rxState_e        state_q, state_d;
    logic [2:0]      bitCnt_q, bitCnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [TO_W-1:0] timeout_q, timeout_d;
    logic            byteValid_q, byteValid_d;
    logic            fallEdge;
    logic            dataS;

    assign dataS    = dataSync_q[1];
    assign fallEdge = clkPrev_q & ~clkSync_q[1];

    // Bring both PS/2 lines into the clk domain; idle-high reset values avoid a false edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            clkPrev_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2Clk_i};
            dataSync_q <= {dataSync_q[0], ps2Data_i};
            clkPrev_q  <= clkSync_q[1];
        end
    end

    // Frame state, shift register and timeout counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            bitCnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            timeout_q   <= '0;
            byteValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            timeout_q   <= timeout_d;
            byteValid_q <= byteValid_d;
        end
    end

    // Advance one frame bit per falling edge; a stalled frame drops back to IDLE.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        byteValid_d = 1'b0;
        timeout_d   = '0;
        if (state_q != IDLE && !fallEdge) begin
            timeout_d = timeout_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (fallEdge && !dataS) begin
                    state_d  = DATA;
                    bitCnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fallEdge) begin
                    shift_d  = {dataS, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fallEdge) begin
                    parity_d = dataS;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fallEdge) begin
                    byteValid_d = dataS & (^{shift_q, parity_q});
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !fallEdge && timeout_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = IDLE;
            timeout_d = '0;
        end
    end

    assign rxByte_o    = shift_q;
    assign byteValid_o = byteValid_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: receives frames, strips break/extended prefixes, queues make
// codes in a FIFO and presents the head with an interrupt request to the CPU.
// Build option PS2_ASCII_EN: translate make codes to ASCII before queuing.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int         FIFO_DEPTH     = 8,
    parameter logic [3:0] IRQ_INDEX      = 4'h3,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2Clk,
    input  logic        ps2Data,
    input  logic        readAck,
    output logic        interruptSignal,
    output logic [3:0]  interruptIndex,
    output logic [15:0] keyboardData,
    output logic        overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]         rxByte;
    logic               rxValid;
    logic               brk_q, brk_d;
    logic               ext_q, ext_d;
    logic               pushReq;
    logic [ENTRY_W-1:0] pushEntry;
    logic               doPush;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q;
    logic [PTR_W-1:0]   rdPtr_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;
    logic               irq_q;
    logic [15:0]        keyboardData_q;
`ifdef PS2_ASCII_EN
    logic [8:0]         asciiLookup;

    assign asciiLookup = scanToAscii(rxByte);
`endif

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uRx (
        .clk_i      (clk),
        .rst_ni     (rst),
        .ps2Clk_i   (ps2Clk),
        .ps2Data_i  (ps2Data),
        .rxByte_o   (rxByte),
        .byteValid_o(rxValid)
    );

    // Prefix flags carry across bytes; only a terminating byte can clear them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
        end else begin
            brk_q <= brk_d;
            ext_q <= ext_d;
        end
    end

    // Decode each received byte into a prefix update, a discard, or a FIFO push.
    always_comb begin
        brk_d     = brk_q;
        ext_d     = ext_q;
        pushReq   = 1'b0;
        pushEntry = '0;
        if (rxValid) begin
            if (rxByte == PS2_BREAK) begin
                brk_d = 1'b1;
            end else if (rxByte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                ext_d = 1'b0;
`ifdef PS2_ASCII_EN
                pushReq   = asciiLookup[8] & ~ext_q;
                pushEntry = {1'b0, asciiLookup[7:0]};
`else
                pushReq   = 1'b1;
                pushEntry = {ext_q, rxByte};
`endif
            end
        end
    end

    assign full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign pop    = readAck & ~empty;
    assign doPush = pushReq & (~full | pop);

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushEntry;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; overflow is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (pushReq && !doPush) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Register the CPU-facing view of the FIFO head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q          <= 1'b0;
            keyboardData_q <= 16'h0000;
        end else begin
            irq_q          <= ~empty;
            keyboardData_q <= empty ? 16'h0000 : {7'b0, mem_q[rdPtr_q]};
        end
    end

    assign interruptSignal = irq_q;
    assign interruptIndex  = IRQ_INDEX;
    assign keyboardData    = keyboardData_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: drives PS/2 frames bit by bit and checks the
// CPU-facing outputs against hand-computed values. Covers the PS2_ASCII_EN build too.
`timescale 1ns/1ps
module tb_ps2_keyboard;

    localparam int HALF = 10;
    localparam int TO   = 1000;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        ps2Clk  = 1'b1;
    logic        ps2Data = 1'b1;
    logic        readAck = 1'b0;
    logic        interruptSignal;
    logic [3:0]  interruptIndex;
    logic [15:0] keyboardData;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    ps2_keyboard #(
        .FIFO_DEPTH    (8),
        .IRQ_INDEX     (4'h3),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ps2Clk         (ps2Clk),
        .ps2Data        (ps2Data),
        .readAck        (readAck),
        .interruptSignal(interruptSignal),
        .interruptIndex (interruptIndex),
        .keyboardData   (keyboardData),
        .overflow       (overflow)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // One PS/2 bit; optionally pulses readAck in the cycle the resulting push lands.
    task automatic ps2Bit(input logic b, input logic ackOnFall);
        ps2Data = b;
        repeat (HALF) @(negedge clk);
        ps2Clk = 1'b0;
        if (ackOnFall) begin
            repeat (3) @(negedge clk);
            readAck = 1'b1;
            @(negedge clk);
            readAck = 1'b0;
            repeat (HALF - 4) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2Clk = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic badParity,
                             input logic stopBit, input logic ackAtStop);
        @(negedge clk);
        ps2Bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(data[i], 1'b0);
        ps2Bit((~^data) ^ badParity, 1'b0);
        ps2Bit(stopBit, ackAtStop);
        ps2Data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic sendGood(input logic [7:0] data);
        sendFrame(data, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic ackPop();
        @(negedge clk);
        readAck = 1'b1;
        @(negedge clk);
        readAck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        checks++; if (interruptSignal !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", interruptSignal); end
        checks++; if (keyboardData !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0000", keyboardData); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); end
        checks++; if (interruptIndex !== 4'h3) begin errors++; $display("[TB] FAIL reset_index: got %h expected 3", interruptIndex); end
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        sendGood(8'h1C);
        checks++; if (interruptSignal !== 1'b1) begin errors++; $display("[TB] FAIL single_irq: got %b expected 1", interruptSignal); end
        checks++; if (keyboardData !== 16'h001C) begin errors++; $display("[TB] FAIL single_data: got %h expected 001c", keyboardData); end
        ackPop();
        checks++; if (interruptSignal !== 1'b0) begin errors++; $display("[TB] FAIL single_pop_irq: got %b expected 0", interruptSignal); end
        checks++; if (keyboardData !== 16'h0000) begin errors++; $display("[TB] FAIL single_pop_data: got %h expected 0000", keyboardData); end
    endtask

    task automatic test_break();
        sendGood(8'hF0);
        sendGood(8'h1C);
        checks++; if (interruptSignal !== 1'b0) begin errors++; $display("[TB] FAIL break_irq: got %b expected 0", interruptSignal); end
        sendGood(8'h1B);
        checks++; if (keyboardData !== 16'h001B) begin errors++; $display("[TB] FAIL break_next: got %h expected 001b", keyboardData); end
        ackPop();
        checks++; if (interruptSignal !== 1'b0) begin errors++; $display("[TB] FAIL break_pop: got %b expected 0", interruptSignal); end
    endtask

    task automatic test_extended();
        sendGood(8'hE0);
        sendGood(8'h75);
        checks++; if (keyboardData !== 16'h0175) begin errors++; $display("[TB] FAIL ext_data: got %h expected 0175", keyboardData); end
        ackPop();
        sendGood(8'hE0);
        sendGood(8'hF0);
        sendGood(8'h75);
        checks++; if (interruptSignal !== 1'b0) begin errors++; $display("[TB] FAIL ext_break_irq: got %b expected 0", interruptSignal); end
        sendGood(8'h1C);
        checks++; if (keyboardData !== 16'h001C) begin errors++; $display("[TB] FAIL ext_cleared: got %h expected 001c", keyboardData); end
        ackPop();
    endtask

    task automatic test_bad_frames();
        sendFrame(8'h1C, 1'b1, 1'b1, 1'b0);
        checks++; if (interruptSignal !== 1'b0) begin errors++; $display("[TB] FAIL bad_parity: got irq %b expected 0", interruptSignal); end
        sendFrame(8'h1C, 1'b0, 1'b0, 1'b0);
        checks++; if (interruptSignal !== 1'b0) begin errors++; $display("[TB] FAIL bad_stop: got irq %b expected 0", interruptSignal); end
        sendGood(8'h23);
        checks++; if (keyboardData !== 16'h0023) begin errors++; $display("[TB] FAIL bad_then_good: got %h expected 0023", keyboardData); end
        ackPop();
    endtask

    task automatic test_overflow();
        logic [7:0] code;
        for (int i = 0; i < 8; i++) begin
            code = 8'h15 + 8'(i);
            sendGood(code);
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_ovf: got %b expected 0", overflow); end
        checks++; if (keyboardData !== 16'h0015) begin errors++; $display("[TB] FAIL fill_head: got %h expected 0015", keyboardData); end
        sendFrame(8'h1D, 1'b0, 1'b1, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_pushpop_ovf: got %b expected 0", overflow); end
        checks++; if (keyboardData !== 16'h0016) begin errors++; $display("[TB] FAIL full_pushpop_head: got %h expected 0016", keyboardData); end
        sendGood(8'h1E);
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_set: got %b expected 1", overflow); end
        for (int i = 0; i < 8; i++) begin
            code = 8'h16 + 8'(i);
            checks++;
            if (keyboardData !== {8'h00, code}) begin
                errors++;
                $display("[TB] FAIL pop_order[%0d]: got %h expected %h", i, keyboardData, {8'h00, code});
            end
            ackPop();
        end
        checks++; if (interruptSignal !== 1'b0) begin errors++; $display("[TB] FAIL drained_irq: got %b expected 0", interruptSignal); end
        checks++; if (keyboardData !== 16'h0000) begin errors++; $display("[TB] FAIL drained_data: got %h expected 0000", keyboardData); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        ps2Bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2Bit(i[0], 1'b0);
        ps2Data = 1'b1;
        repeat (TO + 100) @(negedge clk);
        checks++; if (interruptSignal !== 1'b0) begin errors++; $display("[TB] FAIL timeout_noentry: got irq %b expected 0", interruptSignal); end
        sendGood(8'h16);
        checks++; if (keyboardData !== 16'h0016) begin errors++; $display("[TB] FAIL timeout_recover: got %h expected 0016", keyboardData); end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        ps2Bit(1'b0, 1'b0);
        ps2Bit(1'b1, 1'b0);
        ps2Bit(1'b1, 1'b0);
        ps2Bit(1'b0, 1'b0);
        ps2Data = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (interruptSignal !== 1'b0) begin errors++; $display("[TB] FAIL midrst_irq: got %b expected 0", interruptSignal); end
        checks++; if (keyboardData !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_data: got %h expected 0000", keyboardData); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ovf: got %b expected 0", overflow); end
        checks++; if (interruptIndex !== 4'h3) begin errors++; $display("[TB] FAIL midrst_index: got %h expected 3", interruptIndex); end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        sendGood(8'h23);
        checks++; if (keyboardData !== 16'h0023) begin errors++; $display("[TB] FAIL midrst_recover: got %h expected 0023", keyboardData); end
        ackPop();
        checks++; if (interruptSignal !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pop: got %b expected 0", interruptSignal); end
    endtask

    task automatic test_ascii();
        sendGood(8'h1C);
        checks++; if (keyboardData !== 16'h0061) begin errors++; $display("[TB] FAIL ascii_a: got %h expected 0061", keyboardData); end
        ackPop();
        sendGood(8'h76);
        checks++; if (interruptSignal !== 1'b0) begin errors++; $display("[TB] FAIL ascii_unmapped: got irq %b expected 0", interruptSignal); end
        sendGood(8'hE0);
        sendGood(8'h1C);
        checks++; if (interruptSignal !== 1'b0) begin errors++; $display("[TB] FAIL ascii_ext: got irq %b expected 0", interruptSignal); end
        sendGood(8'h29);
        checks++; if (keyboardData !== 16'h0020) begin errors++; $display("[TB] FAIL ascii_space: got %h expected 0020", keyboardData); end
        ackPop();
        sendGood(8'h45);
        checks++; if (keyboardData !== 16'h0030) begin errors++; $display("[TB] FAIL ascii_zero: got %h expected 0030", keyboardData); end
        ackPop();
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ascii_ovf: got %b expected 0", overflow); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] starting ps2_keyboard bench");
        test_reset();
`ifdef PS2_ASCII_EN
        test_ascii();
        test_reset_mid_frame();
`else
        test_single();
        test_break();
        test_extended();
        test_bad_frames();
        test_overflow();
        test_timeout();
        test_reset_mid_frame();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
